// File: rtl/dmem_responder.sv
// Data-memory responder for the CPU MEM stage: zero-latency lane-selected
// loads, byte-merged stores, sticky misalignment capture and access counters.
// Ports: clk, rst_n (async low); Addr_in/Data_wr/mem_w/mem_r/DMType from the
// CPU; Data_rd load data back; misalign_err/err_addr/rd_cnt/wr_cnt status;
// dbg_idx/dbg_word raw array peek.
module dmem_responder #(
    parameter int DEPTH = 256,
    parameter int AW    = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [31:0]   Addr_in,
    input  logic [31:0]   Data_wr,
    input  logic          mem_w,
    input  logic          mem_r,
    input  logic [2:0]    DMType,
    output logic [31:0]   Data_rd,
    output logic          misalign_err,
    output logic [31:0]   err_addr,
    output logic [31:0]   rd_cnt,
    output logic [31:0]   wr_cnt,
    input  logic [AW-1:0] dbg_idx,
    output logic [31:0]   dbg_word
);

    localparam logic [2:0] T_WORD  = 3'b000;
    localparam logic [2:0] T_HALF  = 3'b001;
    localparam logic [2:0] T_HALFU = 3'b010;
    localparam logic [2:0] T_BYTE  = 3'b011;
    localparam logic [2:0] T_BYTEU = 3'b100;

    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] idx;
    logic [1:0]    off;
    logic          store;
    logic          load;
    logic          mis;
    logic          bad;
    logic [3:0]    be;
    logic [31:0]   wlane;
    logic [31:0]   rword;
    logic [7:0]    rbyte;
    logic [15:0]   rhalf;
    logic [31:0]   ext;

    // Upper address bits alias onto the array
    logic          unused_addr;
    assign unused_addr = ^Addr_in[31:AW+2];

    assign idx   = Addr_in[AW+1:2];
    assign off   = Addr_in[1:0];
    assign store = mem_w;
    assign load  = mem_r & ~mem_w;
    assign bad   = (store | load) & mis;

    // Illegal DMType codes are folded into the misalignment condition
    always_comb begin
        mis = 1'b1;
        case (DMType)
            T_WORD:           mis = |off;
            T_HALF, T_HALFU:  mis = off[0];
            T_BYTE, T_BYTEU:  mis = 1'b0;
            default:          mis = 1'b1;
        endcase
    end

    // Replicate store data across lanes so the byte enables alone select
    always_comb begin
        be    = 4'h0;
        wlane = Data_wr;
        case (DMType)
            T_WORD: be = 4'hF;
            T_HALF, T_HALFU: begin
                be    = off[1] ? 4'hC : 4'h3;
                wlane = {2{Data_wr[15:0]}};
            end
            T_BYTE, T_BYTEU: begin
                be    = 4'b0001 << off;
                wlane = {4{Data_wr[7:0]}};
            end
            default: be = 4'h0;
        endcase
    end

    // Array has no reset; stores during reset are dropped
    always_ff @(posedge clk) begin
        if (rst_n && store && !mis) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) begin
                    mem[idx][8*b +: 8] <= wlane[8*b +: 8];
                end
            end
        end
    end

    assign rword = mem[idx];
    assign rbyte = rword[{off, 3'b000} +: 8];
    assign rhalf = off[1] ? rword[31:16] : rword[15:0];

    always_comb begin
        ext = 32'h0;
        case (DMType)
            T_WORD:  ext = rword;
            T_HALF:  ext = {{16{rhalf[15]}}, rhalf};
            T_HALFU: ext = {16'h0, rhalf};
            T_BYTE:  ext = {{24{rbyte[7]}}, rbyte};
            T_BYTEU: ext = {24'h0, rbyte};
            default: ext = 32'h0;
        endcase
    end

    assign Data_rd  = (rst_n && load && !mis) ? ext : 32'h0;
    assign dbg_word = mem[dbg_idx];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            misalign_err <= 1'b0;
            err_addr     <= 32'h0;
            rd_cnt       <= 32'h0;
            wr_cnt       <= 32'h0;
        end else begin
            if (bad) begin
                misalign_err <= 1'b1;
                if (!misalign_err) begin
                    err_addr <= Addr_in;
                end
            end else if (store) begin
                wr_cnt <= wr_cnt + 32'd1;
            end else if (load) begin
                rd_cnt <= rd_cnt + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized scoreboard bench for dmem_responder against a byte-addressed
// reference memory model.
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] Addr_in;
    logic [31:0] Data_wr;
    logic        mem_w;
    logic        mem_r;
    logic [2:0]  DMType;
    logic [31:0] Data_rd;
    logic        misalign_err;
    logic [31:0] err_addr;
    logic [31:0] rd_cnt;
    logic [31:0] wr_cnt;
    logic [7:0]  dbg_idx;
    logic [31:0] dbg_word;

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH(256), .AW(8)) dut (
        .clk(clk), .rst_n(rst_n), .Addr_in(Addr_in), .Data_wr(Data_wr),
        .mem_w(mem_w), .mem_r(mem_r), .DMType(DMType), .Data_rd(Data_rd),
        .misalign_err(misalign_err), .err_addr(err_addr),
        .rd_cnt(rd_cnt), .wr_cnt(wr_cnt),
        .dbg_idx(dbg_idx), .dbg_word(dbg_word)
    );

    logic [7:0]  mb [1024];
    logic [31:0] m_rd;
    logic [31:0] m_wr;
    logic [31:0] m_ea;
    logic        m_err;
    logic [31:0] q [$];
    int          n_cmp = 0;
    int          n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    function automatic int sz(input logic [2:0] t);
        case (t)
            3'd0:       return 4;
            3'd1, 3'd2: return 2;
            3'd3, 3'd4: return 1;
            default:    return 0;
        endcase
    endfunction

    function automatic bit is_bad(input logic [31:0] a, input logic [2:0] t);
        int s;
        s = sz(t);
        if (s == 0) return 1'b1;
        return (int'(a[1:0]) % s) != 0;
    endfunction

    function automatic logic [31:0] mword(input int i);
        return {mb[4*i+3], mb[4*i+2], mb[4*i+1], mb[4*i]};
    endfunction

    function automatic logic [31:0] mload(input logic [31:0] a,
                                          input logic [2:0] t);
        int o;
        o = int'(a[9:0]);
        case (t)
            3'd0: return {mb[o+3], mb[o+2], mb[o+1], mb[o]};
            3'd1: return {{16{mb[o+1][7]}}, mb[o+1], mb[o]};
            3'd2: return {16'h0, mb[o+1], mb[o]};
            3'd3: return {{24{mb[o][7]}}, mb[o]};
            3'd4: return {24'h0, mb[o]};
            default: return 32'h0;
        endcase
    endfunction

    // Drive one access for a cycle, queue the expected Data_rd, then
    // advance the model to its post-edge state.
    task automatic acc(input logic [31:0] a, input logic [31:0] d,
                       input logic w, input logic r, input logic [2:0] t);
        int o;
        @(posedge clk);
        #1;
        Addr_in = a;
        Data_wr = d;
        mem_w   = w;
        mem_r   = r;
        DMType  = t;
        if (w || r) begin
            q.push_back((w || is_bad(a, t)) ? 32'h0 : mload(a, t));
            if (is_bad(a, t)) begin
                if (!m_err) m_ea = a;
                m_err = 1'b1;
            end else if (w) begin
                o = int'(a[9:0]);
                for (int i = 0; i < sz(t); i++) mb[o+i] = d[8*i +: 8];
                m_wr++;
            end else begin
                m_rd++;
            end
        end
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
        mem_w = 1'b0;
        mem_r = 1'b0;
    endtask

    task automatic chk_st();
        chk("rd_cnt", rd_cnt, m_rd);
        chk("wr_cnt", wr_cnt, m_wr);
        chk("misalign_err", {31'h0, misalign_err}, {31'h0, m_err});
        chk("err_addr", err_addr, m_ea);
    endtask

    task automatic rnd_phase(input int n);
        logic [31:0] a;
        logic [2:0]  t;
        logic        w;
        logic        r;
        for (int k = 0; k < n; k++) begin
            a = $urandom();
            if ($urandom_range(0, 9) < 8) t = 3'($urandom_range(0, 4));
            else t = 3'($urandom_range(5, 7));
            w = 1'($urandom_range(0, 1));
            r = 1'($urandom_range(0, 1));
            acc(a, $urandom(), w, r, t);
        end
    endtask

    // Monitor: every cycle carrying an access presents a Data_rd result
    always @(negedge clk) begin
        if (rst_n && (mem_w || mem_r)) begin
            if (q.size() == 0) begin
                chk("scoreboard_underflow", 32'h1, 32'h0);
            end else begin
                chk("data_rd", Data_rd, q.pop_front());
            end
        end
    end

    initial begin
        rst_n   = 1'b0;
        Addr_in = 32'h0;
        Data_wr = 32'h0;
        mem_w   = 1'b0;
        mem_r   = 1'b0;
        DMType  = 3'd0;
        dbg_idx = 8'h0;
        m_rd    = 32'h0;
        m_wr    = 32'h0;
        m_ea    = 32'h0;
        m_err   = 1'b0;
        #12;
        chk_st();
        chk("data_rd_reset", Data_rd, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 256; i++) acc(32'(i * 4), $urandom(), 1'b1, 1'b0, 3'd0);
        idle();
        chk_st();

        acc(32'h0, 32'h87654321, 1'b1, 1'b0, 3'd0);
        acc(32'h0, 32'h0, 1'b0, 1'b1, 3'd0);
        idle();
        chk_st();
        chk("wr_cnt_abs", wr_cnt, 32'd257);
        chk("rd_cnt_abs", rd_cnt, 32'd1);

        acc(32'h3, 32'h0, 1'b0, 1'b1, 3'd3);
        acc(32'h3, 32'h0, 1'b0, 1'b1, 3'd4);
        acc(32'h2, 32'h0, 1'b0, 1'b1, 3'd1);
        acc(32'h0, 32'h0, 1'b0, 1'b1, 3'd2);

        acc(32'h4, 32'h0, 1'b1, 1'b0, 3'd0);
        acc(32'h5, 32'hFFFFFFAB, 1'b1, 1'b0, 3'd3);
        acc(32'h6, 32'hFFFF1234, 1'b1, 1'b0, 3'd1);
        idle();
        dbg_idx = 8'd1;
        #1;
        chk("lane_merge", dbg_word, 32'h1234AB00);

        acc(32'h2, 32'hFFFFFFFF, 1'b1, 1'b0, 3'd0);
        idle();
        chk_st();
        chk("err_addr_first", err_addr, 32'h2);
        dbg_idx = 8'd0;
        #1;
        chk("mis_store_dropped", dbg_word, 32'h87654321);
        acc(32'h9, 32'h0, 1'b0, 1'b1, 3'd1);
        idle();
        chk("err_addr_sticky", err_addr, 32'h2);

        acc(32'h8, 32'h0000000F, 1'b1, 1'b1, 3'd0);
        idle();
        chk_st();
        dbg_idx = 8'd2;
        #1;
        chk("both_strobes_store", dbg_word, 32'h0000000F);

        acc(32'h10, 32'h0, 1'b0, 1'b1, 3'd7);
        idle();
        chk_st();

        // Async reset between edges, with a store held across one edge
        #2;
        rst_n   = 1'b0;
        Addr_in = 32'h0;
        Data_wr = 32'hDEADBEEF;
        DMType  = 3'd0;
        mem_w   = 1'b1;
        #1;
        chk("rst_rd_cnt", rd_cnt, 32'h0);
        chk("rst_wr_cnt", wr_cnt, 32'h0);
        chk("rst_err", {31'h0, misalign_err}, 32'h0);
        chk("rst_err_addr", err_addr, 32'h0);
        m_rd  = 32'h0;
        m_wr  = 32'h0;
        m_ea  = 32'h0;
        m_err = 1'b0;
        @(posedge clk);
        #1;
        mem_w = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        dbg_idx = 8'd0;
        #1;
        chk("array_kept", dbg_word, 32'h87654321);
        acc(32'h0, 32'h0, 1'b0, 1'b1, 3'd0);
        idle();
        chk_st();

        rnd_phase(600);
        idle();
        chk_st();

        for (int i = 0; i < 256; i++) begin
            dbg_idx = 8'(i);
            #1;
            chk("dbg_sweep", dbg_word, mword(i));
        end
        chk("queue_drained", 32'(q.size()), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
